sync_pattern_detector: RTL and testbench

Parametrised two-word sync-pattern detector and payload gate for the data-bus capture path. The block watches a qualified data bus for SYNC0 followed by SYNC1 within a programmable window. On a match it forwards the next BURST_LEN valid words as a registered write stream (DOUT/WREN) to the downstream buffer. It then reports frame-done or timeout and re-arms.

---
 rtl/sync_pattern_detector_if.sv | 25 ++
 rtl/sync_pattern_detector.sv | 154 +++++++++++++++
 tb/tb_sync_pattern_detector.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_pattern_detector_if.sv
// Capture-path bus between the data source and the sync-pattern detector:
// qualified input word plus the registered write stream and status outputs.
interface sync_pattern_detector_if #(
   parameter int unsigned DW = 16
);
   logic [DW-1:0] DBUS;
   logic          DVALID;
   logic [DW-1:0] DOUT;
   logic          WREN;
   logic          BUSY;
   logic          FRAME_DONE;
   logic          TIMEOUT;
   logic [15:0]   FRAME_CNT;
   logic [15:0]   TMO_CNT;

   modport master (
      output DBUS, DVALID,
      input  DOUT, WREN, BUSY, FRAME_DONE, TIMEOUT, FRAME_CNT, TMO_CNT
   );

   modport slave (
      input  DBUS, DVALID,
      output DOUT, WREN, BUSY, FRAME_DONE, TIMEOUT, FRAME_CNT, TMO_CNT
   );
endinterface

// File: rtl/sync_pattern_detector.sv
// Two-word sync detector and payload gate: SYNC0 then SYNC1 within GAP_MAX cycles
// opens a BURST_LEN-word write stream. Optional frame/timeout counters: SYNC_PATTERN_DETECTOR_STATS_EN.
module sync_pattern_detector #(
   parameter int unsigned    DW        = 16,
   parameter logic [DW-1:0]  SYNC0     = 16'hAAAA,
   parameter logic [DW-1:0]  SYNC1     = 16'h5555,
   parameter int unsigned    GAP_MAX   = 4,
   parameter int unsigned    BURST_LEN = 4
) (
   input logic                  CLK,
   input logic                  RST,
   sync_pattern_detector_if.slave bus
);
   localparam int unsigned GW = $clog2(GAP_MAX + 1);
   localparam int unsigned PW = $clog2(BURST_LEN + 1);
   // gap_q holds (edges since SYNC0) - 1, so the window closes when it reads GAP_MAX-1
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);
   localparam logic [PW-1:0] PAY_LAST = PW'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_SYNC1,
      S_BURST
   } state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [PW-1:0] pay_q, pay_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          wren_q, wren_d;
   logic          busy_q, busy_d;
   logic          frame_done_q, frame_done_d;
   logic          timeout_q, timeout_d;

   logic is_sync0, is_sync1, gap_expired, burst_last;

   assign is_sync0    = bus.DVALID && (bus.DBUS == SYNC0);
   assign is_sync1    = bus.DVALID && (bus.DBUS == SYNC1);
   assign gap_expired = (gap_q == GAP_LAST);
   assign burst_last  = (pay_q == PAY_LAST);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (is_sync0) state_d = S_WAIT_SYNC1;
         end
         S_WAIT_SYNC1: begin
            if (is_sync1)         state_d = S_BURST;
            else if (is_sync0)    state_d = S_WAIT_SYNC1;
            else if (gap_expired) state_d = S_IDLE;
         end
         S_BURST: begin
            if (bus.DVALID && burst_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      gap_d        = gap_q;
      pay_d        = pay_q;
      dout_d       = dout_q;
      wren_d       = 1'b0;
      frame_done_d = 1'b0;
      timeout_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (is_sync0) gap_d = '0;
         end
         S_WAIT_SYNC1: begin
            if (is_sync1)         pay_d = '0;
            else if (is_sync0)    gap_d = '0;
            else if (gap_expired) timeout_d = 1'b1;
            else                  gap_d = gap_q + 1'b1;
         end
         S_BURST: begin
            if (bus.DVALID) begin
               dout_d       = bus.DBUS;
               wren_d       = 1'b1;
               pay_d        = pay_q + 1'b1;
               frame_done_d = burst_last;
            end
         end
         default: ;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         gap_q        <= '0;
         pay_q        <= '0;
         dout_q       <= '0;
         wren_q       <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         gap_q        <= gap_d;
         pay_q        <= pay_d;
         dout_q       <= dout_d;
         wren_q       <= wren_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.DOUT       = dout_q;
   assign bus.WREN       = wren_q;
   assign bus.BUSY       = busy_q;
   assign bus.FRAME_DONE = frame_done_q;
   assign bus.TIMEOUT    = timeout_q;

`ifdef SYNC_PATTERN_DETECTOR_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;

   // Counters step on the same edge as their pulse and stick at all-ones
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      if (frame_done_d && (frame_cnt_q != 16'hFFFF)) frame_cnt_d = frame_cnt_q + 16'd1;
      if (timeout_d && (tmo_cnt_q != 16'hFFFF))      tmo_cnt_d   = tmo_cnt_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         frame_cnt_q <= '0;
         tmo_cnt_q   <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign bus.FRAME_CNT = frame_cnt_q;
   assign bus.TMO_CNT   = tmo_cnt_q;
`else
   assign bus.FRAME_CNT = '0;
   assign bus.TMO_CNT   = '0;
`endif

endmodule

// File: tb/tb_sync_pattern_detector.sv
// Self-checking bench for sync_pattern_detector: directed frames plus random traffic
// compared each cycle against a timestamp-based reference model.
module tb_sync_pattern_detector;
   localparam int          DW        = 16;
   localparam logic [15:0] S0        = 16'hAAAA;
   localparam logic [15:0] S1        = 16'h5555;
   localparam int          GAP_MAX   = 4;
   localparam int          BURST_LEN = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   sync_pattern_detector_if #(.DW(DW)) bus ();

   sync_pattern_detector #(
      .DW(DW), .SYNC0(S0), .SYNC1(S1), .GAP_MAX(GAP_MAX), .BURST_LEN(BURST_LEN)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: edge index of the pending SYNC0 (-1 = none) and words left in the burst
   int          edge_n     = 0;
   int          pend_edge  = -1;
   int          left       = 0;
   int          wren_seen  = 0;
   logic [15:0] e_dout     = '0;
   logic        e_wren     = 1'b0;
   logic        e_busy     = 1'b0;
   logic        e_done     = 1'b0;
   logic        e_tmo      = 1'b0;
   logic [15:0] e_fcnt     = '0;
   logic [15:0] e_tcnt     = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
      end
   endtask

   task automatic model(input logic v, input logic [15:0] d, input logic r);
      e_wren = 1'b0;
      e_done = 1'b0;
      e_tmo  = 1'b0;
      if (r) begin
         pend_edge = -1;
         left      = 0;
         e_dout    = '0;
         e_fcnt    = '0;
         e_tcnt    = '0;
      end else if (left > 0) begin
         if (v) begin
            e_wren = 1'b1;
            e_dout = d;
            left--;
            if (left == 0) begin
               e_done = 1'b1;
`ifdef SYNC_PATTERN_DETECTOR_STATS_EN
               if (e_fcnt != 16'hFFFF) e_fcnt = e_fcnt + 16'd1;
`endif
            end
         end
      end else if (pend_edge >= 0) begin
         if (v && d == S1 && (edge_n - pend_edge) <= GAP_MAX) begin
            left      = BURST_LEN;
            pend_edge = -1;
         end else if (v && d == S0) begin
            pend_edge = edge_n;
         end else if ((edge_n - pend_edge) >= GAP_MAX) begin
            e_tmo     = 1'b1;
            pend_edge = -1;
`ifdef SYNC_PATTERN_DETECTOR_STATS_EN
            if (e_tcnt != 16'hFFFF) e_tcnt = e_tcnt + 16'd1;
`endif
         end
      end else if (v && d == S0) begin
         pend_edge = edge_n;
      end
      e_busy = (pend_edge >= 0) || (left > 0);
   endtask

   task automatic step(input logic v, input logic [15:0] d, input logic r);
      bus.DVALID = v;
      bus.DBUS   = d;
      RST        = r;
      @(posedge CLK);
      model(v, d, r);
      #1;
      if (bus.WREN === 1'b1) wren_seen++;
      check("dout",       32'(bus.DOUT),       32'(e_dout));
      check("wren",       32'(bus.WREN),       32'(e_wren));
      check("busy",       32'(bus.BUSY),       32'(e_busy));
      check("frame_done", 32'(bus.FRAME_DONE), 32'(e_done));
      check("timeout",    32'(bus.TIMEOUT),    32'(e_tmo));
      check("frame_cnt",  32'(bus.FRAME_CNT),  32'(e_fcnt));
      check("tmo_cnt",    32'(bus.TMO_CNT),    32'(e_tcnt));
      edge_n++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
   endtask

   initial begin
      logic [15:0] d;
      bus.DVALID = 1'b0;
      bus.DBUS   = '0;

      // Reset state
      step(1'b0, 16'h0000, 1'b1);
      step(1'b1, S0, 1'b1);
      idle(2);

      // Nominal frame: SYNC1 two cycles after SYNC0, four consecutive payload words
      wren_seen = 0;
      step(1'b1, S0, 1'b0);
      step(1'b0, 16'h0000, 1'b0);
      step(1'b1, S1, 1'b0);
      step(1'b1, 16'h1111, 1'b0);
      step(1'b1, 16'h2222, 1'b0);
      step(1'b1, 16'h3333, 1'b0);
      step(1'b1, 16'h4444, 1'b0);
      check("nominal_wren_count", 32'(wren_seen), 32'd4);
      check("nominal_last_dout", 32'(bus.DOUT), 32'h4444);
      idle(2);

      // Window edge: SYNC1 exactly GAP_MAX edges after SYNC0 is accepted
      wren_seen = 0;
      step(1'b1, S0, 1'b0);
      idle(3);
      step(1'b1, S1, 1'b0);
      for (int i = 0; i < BURST_LEN; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
      check("window_edge_wren_count", 32'(wren_seen), 32'd4);
      idle(2);

      // One cycle too late: timeout, no payload forwarded
      wren_seen = 0;
      step(1'b1, S0, 1'b0);
      step(1'b1, 16'h1234, 1'b0);
      idle(2);
      step(1'b1, 16'h1234, 1'b0);
      check("timeout_pulse", 32'(bus.TIMEOUT), 32'd1);
      step(1'b1, S1, 1'b0);
      for (int i = 0; i < BURST_LEN; i++) step(1'b1, 16'h7777, 1'b0);
      check("late_sync1_wren_count", 32'(wren_seen), 32'd0);
      idle(2);

      // Re-arm: second SYNC0 restarts the window
      wren_seen = 0;
      step(1'b1, S0, 1'b0);
      idle(2);
      step(1'b1, S0, 1'b0);
      idle(2);
      step(1'b1, S1, 1'b0);
      for (int i = 0; i < BURST_LEN; i++) step(1'b1, 16'(16'h0200 + i), 1'b0);
      check("rearm_wren_count", 32'(wren_seen), 32'd4);

      // Back-to-back frame immediately after the last payload edge, stalled burst with sync values
      wren_seen = 0;
      step(1'b1, S0, 1'b0);
      step(1'b1, S1, 1'b0);
      step(1'b1, S0, 1'b0);
      idle(3);
      step(1'b1, S1, 1'b0);
      step(1'b1, 16'h0001, 1'b0);
      step(1'b1, 16'h0002, 1'b0);
      check("stall_done", 32'(bus.FRAME_DONE), 32'd1);
      check("stall_wren_count", 32'(wren_seen), 32'd4);
      idle(2);

      // Reset after the second payload word abandons the frame
      wren_seen = 0;
      step(1'b1, S0, 1'b0);
      step(1'b1, S1, 1'b0);
      step(1'b1, 16'h00A1, 1'b0);
      step(1'b1, 16'h00A2, 1'b0);
      step(1'b0, 16'h0000, 1'b1);
      check("reset_dout", 32'(bus.DOUT), 32'd0);
      step(1'b1, 16'h00A3, 1'b0);
      step(1'b1, 16'h00A4, 1'b0);
      check("reset_abandon_wren_count", 32'(wren_seen), 32'd2);
      step(1'b1, S0, 1'b0);
      step(1'b1, S1, 1'b0);
      for (int i = 0; i < BURST_LEN; i++) step(1'b1, 16'(16'h0300 + i), 1'b0);
      check("after_reset_wren_count", 32'(wren_seen), 32'd6);

      // Random traffic biased toward sync words
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: d = S0;
            3, 4, 5: d = S1;
            default: d = 16'($urandom);
         endcase
         step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 299) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
